uart_echo_sched: RTL
====================

Name: uart_echo_sched

Overview:
- Transmit-side scheduler for the UART echo datapath. Sits between the UART receiver (byte + valid strobe) and the UART transmitter (start/busy handshake).
- Buffers received bytes in a small FIFO and shares the single transmitter between two requesters: the echo FIFO and a message/status port.
- Sequences each byte through the transmitter handshake. Optionally expands CR into CR LF on the echo path.

Parameters:
- DEPTH, 8, echo FIFO depth in bytes; must be a power of 2, minimum 2
- AW, 3, log2(DEPTH)
- CRLF_EXPAND, 1, 1 = an echoed 0x0D is followed by an inserted 0x0A

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset (asserted when 0)
- ECHO_EN  in  1  1 = received bytes are queued for echo
- RX_DATA  in  8  received byte
- RX_VALID  in  1  one-cycle strobe, RX_DATA valid
- MSG_DATA  in  8  message-port byte
- MSG_VALID  in  1  message port requests transmission; held until MSG_READY
- MSG_READY  out  1  one-cycle pulse: MSG_DATA consumed this cycle
- TX_DATA  out  8  byte to transmitter; stable from TX_START until TX_BUSY falls
- TX_START  out  1  one-cycle transmit request
- TX_BUSY  in  1  transmitter busy (shifting a frame)
- FIFO_LEVEL  out  AW+1  echo FIFO occupancy, 0..DEPTH
- OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values: MSG_READY=0, TX_START=0, TX_DATA=0x00, FIFO_LEVEL=0, OVERRUN=0, FSM=IDLE, last_grant=MSG (so echo wins first).
- Reset asserted mid-operation: FIFO emptied, FSM to IDLE immediately, any pending LF discarded, in-flight handshake abandoned.

FIFO push
- Push when RX_VALID && ECHO_EN && (not full, or a pop occurs in the same cycle).
- When full with no pop: byte dropped, OVERRUN set.
- OVERRUN clears only when ECHO_EN=0 or on reset.
- RX_VALID while ECHO_EN=0: ignored, no OVERRUN.
- Pointers are AW bits and wrap modulo DEPTH.
- FIFO_LEVEL is registered; it reflects a push/pop one cycle after the edge.

FSM states: IDLE, START, WAIT_ACK, WAIT_DONE, LF.

IDLE
- Arbitrates when TX_BUSY=0 and at least one requester is pending: FIFO non-empty, or MSG_VALID=1.
- If both are pending: round robin, grant the one not in last_grant. If only one is pending, grant it.
- Echo grant: pop FIFO head into TX_DATA.
- Message grant: latch MSG_DATA into TX_DATA and pulse MSG_READY in that same cycle.
- Update last_grant, then go to START.

START
- TX_START=1 for exactly one cycle, then go to WAIT_ACK.

WAIT_ACK
- Stay until TX_BUSY=1, then go to WAIT_DONE.
- No timeout; the transmitter guarantees it acknowledges.

WAIT_DONE
- Stay until TX_BUSY=0.
- If the granted byte was echo and equals 0x0D and CRLF_EXPAND=1: go to LF.
- Otherwise go to IDLE.

LF
- TX_DATA=0x0A, go to START.
- The LF is not arbitrated: it is always sent immediately after its CR.

Latency
- RX_VALID in cycle n with an idle transmitter and no competing message: FIFO non-empty in n+1, grant in n+1, TX_START high in cycle n+2.
- Back-to-back bytes: next grant occurs on the first IDLE cycle after TX_BUSY falls. There is exactly one IDLE cycle between frames.

Other rules
- Message-only traffic: MSG_DATA accepted at most one byte per frame.
- MSG_VALID dropping before grant is permitted; no byte is sent.

Test Plan:
- Reset low, then high; ECHO_EN=1; RX_VALID with 0x41 "A"; transmitter model asserts TX_BUSY 2 cycles after TX_START for 100 cycles -> TX_START exactly 2 cycles after RX_VALID with TX_DATA=0x41; FIFO_LEVEL goes 1 then 0.
- Push "A","B","C","D","E" back-to-back with TX_BUSY stuck high -> FIFO_LEVEL=5; release TX_BUSY -> bytes transmitted in order 0x41..0x45; FIFO_LEVEL returns to 0.
- DEPTH=8: push 10 bytes with TX_BUSY held high -> FIFO_LEVEL=8, OVERRUN=1, first 8 bytes echoed in order; ECHO_EN=0 clears OVERRUN.
- MSG_VALID with 0x3E held while echo FIFO holds 0x31,0x32 -> transmit order 0x31, 0x3E, 0x32 (round robin); MSG_READY pulses once, in the message grant cycle.
- CRLF_EXPAND=1: echo 0x0D then 0x58 while MSG_VALID is pending -> sequence 0x0D, 0x0A, then message byte, then 0x58. With CRLF_EXPAND=0 -> no 0x0A.
- Assert RESET (0) in WAIT_DONE with 3 bytes queued -> TX_START=0, FIFO_LEVEL=0, OVERRUN=0 immediately; after release, no stale byte is transmitted.

Source files
------------

// File: rtl/uart_echo_sched.sv
// Transmit-side scheduler for the UART echo path: echo FIFO plus message port
// sharing one transmitter, with optional CR -> CR LF expansion on echoed bytes.
module uart_echo_sched #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AW          = 3,
   parameter bit          CRLF_EXPAND = 1'b1
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          ECHO_EN,
   input  logic [7:0]    RX_DATA,
   input  logic          RX_VALID,
   input  logic [7:0]    MSG_DATA,
   input  logic          MSG_VALID,
   output logic          MSG_READY,
   output logic [7:0]    TX_DATA,
   output logic          TX_START,
   input  logic          TX_BUSY,
   output logic [AW:0]   FIFO_LEVEL,
   output logic          OVERRUN
);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_LF
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            overrun_q, overrun_d;
   logic            last_msg_q, last_msg_d;
   logic            echo_q, echo_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            fifo_empty, fifo_full;
   logic            push, pop, grant_msg, msg_ready, tx_start;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LEVEL);

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      last_msg_d = last_msg_q;
      echo_d     = echo_q;
      pop        = 1'b0;
      grant_msg  = 1'b0;
      msg_ready  = 1'b0;
      tx_start   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!TX_BUSY && (!fifo_empty || MSG_VALID)) begin
               // Round robin: message wins only if echo went last or nothing is queued
               grant_msg = MSG_VALID && (fifo_empty || !last_msg_q);
               if (grant_msg) begin
                  tx_data_d  = MSG_DATA;
                  msg_ready  = 1'b1;
                  last_msg_d = 1'b1;
                  echo_d     = 1'b0;
               end else begin
                  tx_data_d  = mem_q[rd_ptr_q];
                  pop        = 1'b1;
                  last_msg_d = 1'b0;
                  echo_d     = 1'b1;
               end
               state_d = S_START;
            end
         end
         S_START: begin
            tx_start = 1'b1;
            state_d  = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (TX_BUSY) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!TX_BUSY) begin
               if (CRLF_EXPAND && echo_q && (tx_data_q == 8'h0D)) state_d = S_LF;
               else                                                state_d = S_IDLE;
            end
         end
         S_LF: begin
            tx_data_d = 8'h0A;
            state_d   = S_START;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      // A full FIFO still accepts a byte when the head leaves in the same cycle
      push      = RX_VALID && ECHO_EN && (!fifo_full || pop);
      wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d   = level_q;
      if (push && !pop)      level_d = level_q + (AW+1)'(1);
      else if (!push && pop) level_d = level_q - (AW+1)'(1);
      overrun_d = overrun_q;
      if (!ECHO_EN)                             overrun_d = 1'b0;
      else if (RX_VALID && fifo_full && !pop)   overrun_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overrun_q  <= 1'b0;
         last_msg_q <= 1'b1;
         echo_q     <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overrun_q  <= overrun_d;
         last_msg_q <= last_msg_d;
         echo_q     <= echo_d;
         tx_data_q  <= tx_data_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= RX_DATA;
   end

   assign MSG_READY  = msg_ready;
   assign TX_START   = tx_start;
   assign TX_DATA    = tx_data_q;
   assign FIFO_LEVEL = level_q;
   assign OVERRUN    = overrun_q;
endmodule
